// File: rtl/nr_pkg.sv
// Shared nanoRisk definitions for the multi-cycle multiply/divide sequencer.
package nr_pkg;

    localparam int unsigned NR_WORD = 8;

    localparam logic [1:0] NR_MD_MULU = 2'b00;
    localparam logic [1:0] NR_MD_DIVU = 2'b01;

    localparam logic [1:0] NR_MD_OK    = 2'b00;
    localparam logic [1:0] NR_MD_DZ    = 2'b01;
    localparam logic [1:0] NR_MD_BADOP = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } md_state_e;

endpackage

// File: rtl/nr_muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide on {hi,lo}.
module nr_muldiv_step
    import nr_pkg::*;
(
    input  logic [1:0]         op,
    input  logic [NR_WORD-1:0] hi,
    input  logic [NR_WORD-1:0] lo,
    input  logic [NR_WORD-1:0] b,
    output logic [NR_WORD-1:0] hi_nxt,
    output logic [NR_WORD-1:0] lo_nxt
);

    logic [NR_WORD:0]   sum9;
    logic [NR_WORD:0]   shifted;
    logic [NR_WORD+1:0] trial;

    always_comb begin
        sum9    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[NR_WORD-1]};
        // Extra top bit catches the borrow when the shifted remainder is smaller than b.
        trial   = {1'b0, shifted} - {2'b00, b};
        hi_nxt  = hi;
        lo_nxt  = lo;
        case (op)
            NR_MD_MULU: begin
                hi_nxt = sum9[NR_WORD:1];
                lo_nxt = {sum9[0], lo[NR_WORD-1:1]};
            end
            NR_MD_DIVU: begin
                if (!trial[NR_WORD+1]) begin
                    hi_nxt = trial[NR_WORD-1:0];
                    lo_nxt = {lo[NR_WORD-2:0], 1'b1};
                end else begin
                    hi_nxt = shifted[NR_WORD-1:0];
                    lo_nxt = {lo[NR_WORD-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nr_muldiv_seq.sv
// Multi-cycle unsigned 8-bit multiply/divide sequencer: FSM, iteration counter and
// result registers around the combinational nr_muldiv_step datapath.
module nr_muldiv_seq
    import nr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [NR_WORD-1:0] in0,
    input  logic [NR_WORD-1:0] in1,
    output logic               busy,
    output logic               done,
    output logic [NR_WORD-1:0] out_hi,
    output logic [NR_WORD-1:0] out_lo,
    output logic               zero,
    output logic [1:0]         err
);

    md_state_e          state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [NR_WORD-1:0] b_q, b_d;
    logic [NR_WORD-1:0] hi_q, hi_d;
    logic [NR_WORD-1:0] lo_q, lo_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [NR_WORD-1:0] res_hi_q, res_hi_d;
    logic [NR_WORD-1:0] res_lo_q, res_lo_d;
    logic               zero_q, zero_d;
    logic [1:0]         err_q, err_d;
    logic [NR_WORD-1:0] step_hi, step_lo;

    nr_muldiv_step u_step (
        .op     (op_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .b      (b_q),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (op[1]) begin
                        state_d  = StDone;
                        res_hi_d = '0;
                        res_lo_d = '0;
                        zero_d   = 1'b1;
                        err_d    = NR_MD_BADOP;
                    end else if (op == NR_MD_DIVU && in1 == '0) begin
                        // Divide-by-zero skips iteration; {dividend, all-ones} is never zero.
                        state_d  = StDone;
                        res_hi_d = in0;
                        res_lo_d = '1;
                        zero_d   = 1'b0;
                        err_d    = NR_MD_DZ;
                    end else begin
                        state_d = StRun;
                        op_d    = op;
                        b_d     = in1;
                        hi_d    = '0;
                        lo_d    = in0;
                        cnt_d   = '0;
                    end
                end
            end
            StRun: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d  = StDone;
                    res_hi_d = step_hi;
                    res_lo_d = step_lo;
                    zero_d   = ({step_hi, step_lo} == '0);
                    err_d    = NR_MD_OK;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= NR_MD_MULU;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= NR_MD_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign out_hi = res_hi_q;
    assign out_lo = res_lo_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_nr_muldiv_seq.sv
// Directed self-checking bench for nr_muldiv_seq with hand-computed expected results.
module tb_nr_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] in0, in1;
    logic       busy, done, zero;
    logic [7:0] out_hi, out_lo;
    logic [1:0] err;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    nr_muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .in0    (in0),
        .in1    (in1),
        .busy   (busy),
        .done   (done),
        .out_hi (out_hi),
        .out_lo (out_lo),
        .zero   (zero),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        op    = o;
        in0   = a;
        in1   = b;
        tick();
        start = 1'b0;
        op    = 2'b10;
        in0   = 8'hA5;
        in1   = 8'h5A;
    endtask

    // Counts cycles after the accepting edge until done; poke drives stray starts in cycles 3-5.
    task automatic wait_done(input bit poke, output int lat, output bit busy_seen);
        lat       = 1;
        busy_seen = 1'b0;
        while (!done && lat <= 20) begin
            if (busy) busy_seen = 1'b1;
            if (busy && done) overlap++;
            if (poke && lat >= 3 && lat <= 5) begin
                start = 1'b1;
                op    = 2'b01;
                in0   = 8'd9;
                in1   = 8'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        if (busy && done) overlap++;
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [15:0] exp_res, input logic exp_zero,
                                input logic [1:0] exp_err);
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_res"}, {out_hi, out_lo}, exp_res);
        check({tag, "_zero"}, {15'd0, zero}, {15'd0, exp_zero});
        check({tag, "_err"}, {14'd0, err}, {14'd0, exp_err});
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [15:0] exp_res,
                       input logic exp_zero, input logic [1:0] exp_err);
        int lat;
        bit bs;
        tick();
        issue(o, a, b);
        wait_done(1'b0, lat, bs);
        check_result(tag, lat, exp_lat, exp_res, exp_zero, exp_err);
        check({tag, "_busy_seen"}, {15'd0, bs}, {15'd0, (exp_lat != 1)});
    endtask

    initial begin
        int  lat;
        bit  bs;
        int  done_seen;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        in0   = 8'h00;
        in1   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_res", {out_hi, out_lo}, 16'h0000);
        check("rst_zero", {15'd0, zero}, 16'd1);
        check("rst_err", {14'd0, err}, 16'd0);

        run("mul_13x11", 2'b00, 8'd13, 8'd11, 9, 16'h008F, 1'b0, 2'b00);
        run("mul_255x255", 2'b00, 8'd255, 8'd255, 9, 16'hFE01, 1'b0, 2'b00);
        run("mul_0x77", 2'b00, 8'd0, 8'd77, 9, 16'h0000, 1'b1, 2'b00);
        run("div_200_7", 2'b01, 8'd200, 8'd7, 9, 16'h041C, 1'b0, 2'b00);
        run("div_5_9", 2'b01, 8'd5, 8'd9, 9, 16'h0500, 1'b0, 2'b00);
        run("div_42_0", 2'b01, 8'd42, 8'd0, 1, 16'h2AFF, 1'b0, 2'b01);
        run("badop_11", 2'b11, 8'd42, 8'd7, 1, 16'h0000, 1'b1, 2'b10);

        // Stray starts during RUN are ignored, then a back-to-back start from the DONE cycle.
        tick();
        issue(2'b00, 8'd13, 8'd11);
        wait_done(1'b1, lat, bs);
        check_result("ignore_start", lat, 9, 16'h008F, 1'b0, 2'b00);
        issue(2'b01, 8'd100, 8'd10);
        check("b2b_busy", {15'd0, busy}, 16'd1);
        wait_done(1'b0, lat, bs);
        check_result("b2b_div", lat, 9, 16'h000A, 1'b0, 2'b00);

        // Reset mid-RUN discards the partial result and suppresses done.
        tick();
        issue(2'b00, 8'd200, 8'd3);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_done", {15'd0, done}, 16'd0);
        check("midrst_res", {out_hi, out_lo}, 16'h0000);
        check("midrst_zero", {15'd0, zero}, 16'd1);
        check("midrst_err", {14'd0, err}, 16'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("midrst_quiet", 16'(done_seen), 16'd0);
        run("mul_3x4", 2'b00, 8'd3, 8'd4, 9, 16'h000C, 1'b0, 2'b00);

        check("busy_done_overlap", 16'(overlap), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
